instruction_fetch_controller: RTL
=================================

// Module: instruction_fetch_controller
// PURPOSE
//  Owns the single port of instruction_memory. After reset it grants the port to a program loader for writes.
//  After ld_done it streams sequential instruction fetches to the CPU decode stage.
//  Hides the memory's 1-cycle synchronous read latency, supports stall and zero-bubble redirect.
//  Halts on out-of-range addresses.
// PARAMETERS
//  ADDR_W    16    memory word-address width
//  DATA_W    32    instruction width
//  MEM_SIZE  1660  populated words; legal addresses are 0..MEM_SIZE-1
//  RESET_PC  0     first fetch address after ld_done
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous active-low reset
//  ld_valid       in   1       loader write request
//  ld_ready       out  1       loader write accepted this cycle
//  ld_addr        in   ADDR_W  loader word address
//  ld_data        in   DATA_W  loader write data
//  ld_done        in   1       pulse: program load finished, begin RUN
//  reload         in   1       pulse: abandon RUN/HALT, return to LOAD
//  stall          in   1       decode cannot accept; hold presented instruction
//  redirect_valid in   1       branch/jump taken
//  redirect_pc    in   ADDR_W  redirect target
//  fetch_valid    out  1       fetch_inst/fetch_pc are valid
//  fetch_pc       out  ADDR_W  address of presented instruction
//  fetch_inst     out  DATA_W  presented instruction (= mem_rd)
//  mem_a          out  ADDR_W  memory address
//  mem_we         out  1       memory write enable
//  mem_wd         out  DATA_W  memory write data
//  mem_rd         in   DATA_W  memory read data; reflects mem_a of previous cycle
//  halted         out  1       state == HALT
//  oob_err        out  1       sticky: out-of-range load address, redirect target, or sequential overrun
// BEHAVIOUR
//  Reset (rst_n=0 at edge)
//   state=LOAD, pc_q=0, valid_q=0, oob_err=0.
//   While rst_n=0, all outputs are forced: ld_ready=0, mem_we=0, mem_a=0, fetch_valid=0.
//  LOAD
//   ld_ready=1.
//   ld_valid=1: mem_we=1, mem_a=ld_addr, mem_wd=ld_data.
//   ld_valid=1 with ld_addr>=MEM_SIZE: mem_we=0 (write dropped), ld_ready still 1, oob_err<=1.
//   ld_valid=0: mem_we=0, mem_a=0.
//   ld_done: next state RUN, valid_q<=0. A write in the same cycle as ld_done is performed first.
//   stall, redirect_valid and reload are ignored.
//  RUN
//   ld_ready=0, mem_we=0.
//   fetch_valid=valid_q, fetch_pc=pc_q, fetch_inst=mem_rd (combinational pass-through).
//   Issue address na, evaluated in priority order:
//     1 redirect_valid       -> redirect_pc
//     2 !valid_q (priming)   -> RESET_PC; stall is ignored
//     3 stall                -> pc_q (re-read, so mem_rd stays stable)
//     4 otherwise            -> pc_q+1
//   mem_a=na, pc_q<=na, valid_q<=1.
//   Latency: ld_done at cycle N -> fetch_valid=1, fetch_pc=RESET_PC at cycle N+2.
//   Redirect in cycle T -> target presented at T+1, no bubble; the instruction presented in cycle T stays valid.
//   Range checks (na>=MEM_SIZE):
//     redirect_pc>=MEM_SIZE, or sequential na==MEM_SIZE -> no fetch issued; state<=HALT, valid_q<=0, oob_err<=1.
//     Only the wrap-free case applies: MEM_SIZE-1 is the last address presented.
//  HALT
//   fetch_valid=0, mem_we=0, mem_a=pc_q. Left only by reload or reset.
//  reload
//   In RUN or HALT: next state LOAD, valid_q<=0; fetch_valid=0 from the next cycle. reload outranks redirect and stall.
//  oob_err: sticky; cleared only by reset (not by reload).
// TESTING
//  T1: reset; load 0:A,1:B,2:C; ld_done -> two cycles later fetch_pc 0,1,2 with A,B,C on consecutive cycles.
//  T2: RUN at pc 5; stall high 3 cycles -> fetch_pc=5 and same fetch_inst held 3 cycles; pc 6 on first cycle after release.
//  T3: redirect_valid with redirect_pc=0x10, same cycle as stall -> next cycle fetch_pc=0x10, valid, no bubble.
//  T4: MEM_SIZE=8; run from 0 -> pc 7 presented, then halted=1, oob_err=1, fetch_valid=0.
//      Separately, redirect_pc=0x20 (>=MEM_SIZE) -> halted=1, oob_err=1.
//  T5: LOAD write ld_addr=MEM_SIZE -> mem_we=0, oob_err=1. Write with ld_done same cycle -> write lands, RUN entered.
//  T6: rst_n=0 mid-RUN -> next cycle LOAD, fetch_valid=0, oob_err=0. reload from HALT -> LOAD, oob_err retained.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - single-port instruction memory owner: program loader, then sequential fetch
//
// Purpose:
//   Arbitrates the one port of the instruction memory. Out of reset the port
//   belongs to a program loader (writes). After ld_done the block streams
//   sequential fetches to the decode stage. It hides the memory's one-cycle
//   synchronous read latency, and it supports stall and zero-bubble redirect.
//   It halts when a fetch would leave the populated address range.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_addr/
//   ld_data/ld_done                loader write channel and end-of-load pulse
//   reload                         return to LOAD from RUN or HALT
//   stall                          decode cannot accept; hold presented instruction
//   redirect_valid/redirect_pc     taken branch/jump target
//   fetch_valid/fetch_pc/
//   fetch_inst                     instruction presented to decode
//   mem_a/mem_we/mem_wd/mem_rd     instruction memory port (mem_rd lags mem_a by one cycle)
//   halted                         controller is in HALT
//   oob_err                        sticky out-of-range indication, cleared only by reset

module instruction_fetch_controller #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MEM_SIZE = 1660,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              reload,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [DATA_W-1:0] fetch_inst,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              halted,
  output logic              oob_err
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Range limit is kept one bit wider than an address so that a MEM_SIZE of
  // 2**ADDR_W and the pc_q+1 overrun are both representable.
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              oob_q, oob_d;

  logic [ADDR_W:0]   seq_pc;
  logic              ld_in_range;
  logic              redir_in_range;
  logic [ADDR_W-1:0] na;
  logic              na_oob;

  assign seq_pc         = {1'b0, pc_q} + (ADDR_W+1)'(1);
  assign ld_in_range    = ({1'b0, ld_addr} < MEM_LIMIT);
  assign redir_in_range = ({1'b0, redirect_pc} < MEM_LIMIT);

  // Next issue address. pc_q always names the address whose data arrives on
  // mem_rd this cycle, so the presented instruction is a pure pass-through.
  // A stall re-reads pc_q so mem_rd keeps showing the held instruction.
  always_comb begin
    na     = pc_q;
    na_oob = 1'b0;
    if (redirect_valid) begin
      na     = redirect_pc;
      na_oob = !redir_in_range;
    end else if (!valid_q) begin
      na     = START_PC;
    end else if (stall) begin
      na     = pc_q;
    end else begin
      na     = seq_pc[ADDR_W-1:0];
      na_oob = (seq_pc >= MEM_LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    oob_d       = oob_q;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = ld_data;
    fetch_valid = 1'b0;

    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_a = ld_addr;
          // Out-of-range writes are still accepted so the loader never
          // deadlocks, but they never reach the memory.
          if (ld_in_range) begin
            mem_we = 1'b1;
          end else begin
            oob_d = 1'b1;
          end
        end
        // A write presented with ld_done lands on the same edge.
        if (ld_done) begin
          state_d = ST_RUN;
          valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        fetch_valid = valid_q;
        if (reload) begin
          state_d = ST_LOAD;
          valid_d = 1'b0;
          mem_a   = pc_q;
        end else if (na_oob) begin
          // No fetch is issued for an illegal address; the instruction
          // presented this cycle is the last one decode sees.
          state_d = ST_HALT;
          valid_d = 1'b0;
          oob_d   = 1'b1;
          mem_a   = pc_q;
        end else begin
          mem_a   = na;
          pc_d    = na;
          valid_d = 1'b1;
        end
      end

      ST_HALT: begin
        mem_a = pc_q;
        if (reload) begin
          state_d = ST_LOAD;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOAD;
        valid_d = 1'b0;
      end
    endcase

    // Port is quiet while reset is held, whatever the current state.
    if (!rst_n) begin
      ld_ready    = 1'b0;
      mem_we      = 1'b0;
      mem_a       = '0;
      fetch_valid = 1'b0;
    end
  end

  assign fetch_pc   = pc_q;
  assign fetch_inst = mem_rd;
  assign halted     = (state_q == ST_HALT);
  assign oob_err    = oob_q;

endmodule
